// File: rtl/execute_fwd_mul_if.sv
// execute_fwd_mul_if: bundle of every non-clock signal of the EX stage.
//   master : ID side / pipeline driver. Drives the *_in fields, ihit, flush and
//            the forwarding sources. Observes the EX results and ex_stall.
//   slave  : the EX stage itself.
// fwd_addr and fwd_data are flat vectors. Source i occupies slice [i*W +: W],
// and index 0 is the youngest, highest-priority source.
interface execute_fwd_mul_if #(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5,
  parameter int NFWD   = 2
);
  logic                     ihit;
  logic                     flush;
  logic [REG_AW-1:0]        rsel1_in;
  logic [REG_AW-1:0]        rsel2_in;
  logic [WORD_W-1:0]        rdat1_in;
  logic [WORD_W-1:0]        rdat2_in;
  logic [WORD_W-1:0]        imm_in;
  logic [WORD_W-1:0]        shamt_in;
  logic [1:0]               alusrc_in;
  logic [3:0]               aluop_in;
  logic [WORD_W-1:0]        npc_in;
  logic                     dren_in;
  logic                     dwen_in;
  logic                     regwr_in;
  logic                     halt_in;
  logic [REG_AW-1:0]        regdst_in;
  logic [NFWD-1:0]          fwd_wen;
  logic [NFWD*REG_AW-1:0]   fwd_addr;
  logic [NFWD*WORD_W-1:0]   fwd_data;
  logic [WORD_W-1:0]        result;
  logic                     zero;
  logic [WORD_W-1:0]        store_dat;
  logic [WORD_W-1:0]        npc_out;
  logic                     dren_out;
  logic                     dwen_out;
  logic                     regwr_out;
  logic                     halt_out;
  logic [REG_AW-1:0]        regdst_out;
  logic                     ex_stall;

  modport master (
    output ihit, flush, rsel1_in, rsel2_in, rdat1_in, rdat2_in, imm_in, shamt_in,
           alusrc_in, aluop_in, npc_in, dren_in, dwen_in, regwr_in, halt_in,
           regdst_in, fwd_wen, fwd_addr, fwd_data,
    input  result, zero, store_dat, npc_out, dren_out, dwen_out, regwr_out,
           halt_out, regdst_out, ex_stall
  );

  modport slave (
    input  ihit, flush, rsel1_in, rsel2_in, rdat1_in, rdat2_in, imm_in, shamt_in,
           alusrc_in, aluop_in, npc_in, dren_in, dwen_in, regwr_in, halt_in,
           regdst_in, fwd_wen, fwd_addr, fwd_data,
    output result, zero, store_dat, npc_out, dren_out, dwen_out, regwr_out,
           halt_out, regdst_out, ex_stall
  );
endinterface

// File: rtl/execute_fwd_mul.sv
// execute_fwd_mul: EX stage of the pipelined core.
// It holds the ID/EX register (with flush and stall), N-source forwarding for
// rs/rt, a WORD_W-bit ALU, and an iterative shift-add multiplier. While a
// multiply runs, the multiplier holds the front end.
// Ports:
//   CLK, nRST : clock, and the asynchronous active-low reset.
//   ex        : execute_fwd_mul_if.slave. Carries the ID inputs, the forwarding
//               sources, the EX results, the registered control and ex_stall.
//
// state | meaning
// IDLE  | no multiply in flight; a latched MUL starts one next cycle
// LOAD  | capture forwarded operands, clear accumulator and counter
// RUN   | one shift-add iteration per cycle, WORD_W iterations
// DONE  | product in acc; the next latch returns to IDLE
module execute_fwd_mul #(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5,
  parameter int NFWD   = 2
) (
  input logic              CLK,
  input logic              nRST,
  execute_fwd_mul_if.slave ex
);
  localparam int SHW = $clog2(WORD_W);
  localparam int CW  = $clog2(WORD_W + 1);
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;
  state_t state, state_nx;

  logic [REG_AW-1:0] rsel1, rsel2, regdst;
  logic [WORD_W-1:0] rdat1, rdat2, imm, shamt, npc;
  logic [1:0]        alusrc;
  logic [3:0]        aluop;
  logic              dren, dwen, regwr, halt;

  logic [WORD_W-1:0] acc, mcand, mplier;
  logic [CW-1:0]     cnt;

  logic [WORD_W-1:0] opa, opb_rt, portb, alu_res;
  logic              stall, load;

  assign stall = (aluop == OP_MUL) && (state != S_DONE);
  assign load  = ex.ihit && !stall;

  // ID/EX register. A flush takes priority over a load.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST || ex.flush) begin
      rsel1 <= '0; rsel2 <= '0; rdat1 <= '0; rdat2 <= '0;
      imm <= '0; shamt <= '0; alusrc <= '0; aluop <= '0; npc <= '0;
      dren <= 1'b0; dwen <= 1'b0; regwr <= 1'b0; halt <= 1'b0; regdst <= '0;
    end else if (load) begin
      rsel1 <= ex.rsel1_in; rsel2 <= ex.rsel2_in;
      rdat1 <= ex.rdat1_in; rdat2 <= ex.rdat2_in;
      imm <= ex.imm_in; shamt <= ex.shamt_in;
      alusrc <= ex.alusrc_in; aluop <= ex.aluop_in; npc <= ex.npc_in;
      dren <= ex.dren_in; dwen <= ex.dwen_in; regwr <= ex.regwr_in;
      halt <= ex.halt_in; regdst <= ex.regdst_in;
    end
  end

  // Sources are walked from oldest to youngest so that the lowest index wins.
  always_comb begin
    opa    = rdat1;
    opb_rt = rdat2;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (ex.fwd_wen[i] && (rsel1 != '0) && (ex.fwd_addr[i*REG_AW +: REG_AW] == rsel1))
        opa = ex.fwd_data[i*WORD_W +: WORD_W];
      if (ex.fwd_wen[i] && (rsel2 != '0) && (ex.fwd_addr[i*REG_AW +: REG_AW] == rsel2))
        opb_rt = ex.fwd_data[i*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    portb = '0;
    case (alusrc)
      2'd0:    portb = opb_rt;
      2'd1:    portb = imm;
      2'd2:    portb = shamt;
      default: portb = '0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (aluop)
      4'd0:    alu_res = opa << portb[SHW-1:0];
      4'd1:    alu_res = opa >> portb[SHW-1:0];
      4'd2:    alu_res = opa + portb;
      4'd3:    alu_res = opa - portb;
      4'd4:    alu_res = opa & portb;
      4'd5:    alu_res = opa | portb;
      4'd6:    alu_res = opa ^ portb;
      4'd7:    alu_res = ~(opa | portb);
      4'd8:    alu_res = {{(WORD_W-1){1'b0}}, ($signed(opa) < $signed(portb))};
      4'd9:    alu_res = {{(WORD_W-1){1'b0}}, (opa < portb)};
      4'd10:   alu_res = acc;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (aluop == OP_MUL) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_RUN;
      S_RUN:   if (cnt == CW'(WORD_W - 1)) state_nx = S_DONE;
      S_DONE:  if (load) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (ex.flush) state_nx = S_IDLE;
  end

  // The operands are frozen at LOAD, so forwarding changes during RUN have no
  // effect on the product.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST || ex.flush) begin
      acc <= '0; mcand <= '0; mplier <= '0; cnt <= '0;
    end else if (state == S_LOAD) begin
      acc <= '0; mcand <= opa; mplier <= portb; cnt <= '0;
    end else if (state == S_RUN) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

  assign ex.result     = alu_res;
  assign ex.zero       = (alu_res == '0);
  assign ex.store_dat  = opb_rt;
  assign ex.npc_out    = npc;
  assign ex.dren_out   = dren;
  assign ex.dwen_out   = dwen;
  assign ex.regwr_out  = regwr;
  assign ex.halt_out   = halt;
  assign ex.regdst_out = regdst;
  assign ex.ex_stall   = stall;
endmodule

// File: tb/tb_execute_fwd_mul.sv
module tb_execute_fwd_mul;
  logic CLK = 1'b0;
  logic nRST;
  int checks = 0;
  int errors = 0;
  logic [31:0] npc_ctr = 32'h100;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        chk_st;
    logic [31:0] st;
    int          stall;
    logic [31:0] npc;
  } exp_t;
  exp_t q[$];

  execute_fwd_mul_if #(.WORD_W(32), .REG_AW(5), .NFWD(2)) bus();
  execute_fwd_mul #(.WORD_W(32), .REG_AW(5), .NFWD(2)) dut (.CLK(CLK), .nRST(nRST), .ex(bus));

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one instruction and holds ihit until it latches.
  task automatic issue(input string nm, input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [1:0] src,
                       input logic [31:0] exp_res, input logic chk_st, input logic [31:0] exp_st,
                       input int exp_stall, input bit push);
    exp_t e;
    int n;
    bus.aluop_in = op; bus.rsel1_in = rs; bus.rsel2_in = rt;
    bus.rdat1_in = d1; bus.rdat2_in = d2; bus.alusrc_in = src;
    bus.npc_in = npc_ctr; npc_ctr += 32'd4;
    bus.regwr_in = 1'b1; bus.regdst_in = 5'd9;
    if (push) begin
      e.name = nm; e.res = exp_res; e.chk_st = chk_st; e.st = exp_st;
      e.stall = exp_stall; e.npc = bus.npc_in;
      q.push_back(e);
    end
    n = 0;
    while (bus.ex_stall && n < 100) begin tick(); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL %s_latch_timeout: stall still %b expected 0", nm, bus.ex_stall);
    end
    bus.ihit = 1'b1;
    tick();
    bus.ihit = 1'b0;
  endtask

  // Monitor: an output is presented at the first non-stalled negedge after a latch.
  initial begin : monitor
    bit pend = 0, lat_prev = 0, fl_prev = 0;
    int scnt = 0;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        pend = 0; lat_prev = 0; fl_prev = 0;
      end else begin
        if (fl_prev) pend = 0;
        else if (lat_prev) begin pend = 1; scnt = 0; end
        if (pend) begin
          if (bus.ex_stall) scnt++;
          else begin
            pend = 0;
            if (q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_output: result %h with empty queue", bus.result);
            end else begin
              e = q.pop_front();
              chk({e.name, "_result"}, bus.result, e.res);
              chk({e.name, "_zero"}, {31'd0, bus.zero}, {31'd0, (e.res == 32'd0)});
              chk({e.name, "_npc"}, bus.npc_out, e.npc);
              if (e.chk_st) chk({e.name, "_store"}, bus.store_dat, e.st);
              if (e.stall >= 0) chk({e.name, "_stall_cycles"}, scnt, e.stall);
            end
          end
        end
        lat_prev = bus.ihit && !bus.ex_stall && !bus.flush;
        fl_prev  = bus.flush;
      end
    end
  end

  initial begin : stim
    int n;
    nRST = 1'b0;
    bus.ihit = 0; bus.flush = 0; bus.rsel1_in = 0; bus.rsel2_in = 0;
    bus.rdat1_in = 0; bus.rdat2_in = 0; bus.imm_in = 0; bus.shamt_in = 0;
    bus.alusrc_in = 0; bus.aluop_in = 0; bus.npc_in = 0; bus.dren_in = 0;
    bus.dwen_in = 0; bus.regwr_in = 0; bus.halt_in = 0; bus.regdst_in = 0;
    bus.fwd_wen = 0; bus.fwd_addr = 0; bus.fwd_data = 0;
    tick(); tick();
    chk("reset_result", bus.result, 32'd0);
    chk("reset_zero", {31'd0, bus.zero}, 32'd1);
    chk("reset_stall", {31'd0, bus.ex_stall}, 32'd0);
    nRST = 1'b1;
    tick();

    // Reset in the middle of a multiply.
    issue("mul_rst", 4'd10, 5'd1, 5'd2, 32'd7, 32'd9, 2'd0, 0, 0, 0, -1, 0);
    repeat (11) tick();
    chk("pre_rst_stall", {31'd0, bus.ex_stall}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("rst_result", bus.result, 32'd0);
    chk("rst_zero", {31'd0, bus.zero}, 32'd1);
    chk("rst_stall", {31'd0, bus.ex_stall}, 32'd0);
    chk("rst_npc", bus.npc_out, 32'd0);
    chk("rst_regwr", {31'd0, bus.regwr_out}, 32'd0);
    tick(); tick();
    nRST = 1'b1;
    tick();

    // Forwarding priority: source 0 wins.
    bus.fwd_wen = 2'b11; bus.fwd_addr = {5'd4, 5'd4}; bus.fwd_data = {32'd100, 32'd200};
    issue("add_fwd", 4'd2, 5'd3, 5'd4, 32'd5, 32'd7, 2'd0, 32'd205, 1, 32'd200, 0, 1);
    tick();
    bus.fwd_wen = 2'b00;

    issue("slt", 4'd8, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'd1, 2'd0, 32'd1, 1, 32'd1, 0, 1);
    issue("sltu", 4'd9, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'd1, 2'd0, 32'd0, 0, 0, 0, 1);
    issue("sub", 4'd3, 5'd1, 5'd2, 32'd5, 32'd5, 2'd0, 32'd0, 0, 0, 0, 1);
    bus.shamt_in = 32'd4;
    issue("sll", 4'd0, 5'd1, 5'd2, 32'd1, 32'd99, 2'd2, 32'd16, 0, 0, 0, 1);
    bus.imm_in = 32'h23;
    issue("srl", 4'd1, 5'd1, 5'd2, 32'h8000_0000, 32'd99, 2'd1, 32'h1000_0000, 0, 0, 0, 1);
    issue("and", 4'd4, 5'd1, 5'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 2'd0, 32'h00F0_1234, 0, 0, 0, 1);
    issue("or",  4'd5, 5'd1, 5'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 2'd0, 32'hFFF0_FFFF, 0, 0, 0, 1);
    issue("xor", 4'd6, 5'd1, 5'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 2'd0, 32'hFF00_EDCB, 0, 0, 0, 1);
    issue("nor", 4'd7, 5'd1, 5'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 2'd0, 32'h000F_0000, 0, 0, 0, 1);
    issue("op12", 4'd12, 5'd1, 5'd2, 32'd3, 32'd4, 2'd0, 32'd0, 0, 0, 0, 1);
    issue("add_zero_b", 4'd2, 5'd1, 5'd2, 32'h11, 32'd4, 2'd3, 32'h11, 0, 0, 0, 1);

    // Multiply, then a queued ADD that latches on the first non-stall edge.
    issue("mul_a", 4'd10, 5'd1, 5'd2, 32'h0001_0003, 32'd5, 2'd0, 32'h0005_000F, 0, 0, 34, 1);
    issue("add_after_mul", 4'd2, 5'd1, 5'd2, 32'd2, 32'd3, 2'd0, 32'd5, 0, 0, 0, 1);

    // Signed operands through forwarding; the source changes during RUN.
    bus.fwd_wen = 2'b01; bus.fwd_addr = {5'd0, 5'd6}; bus.fwd_data = {32'd0, 32'hFFFF_FFFF};
    issue("mul_neg", 4'd10, 5'd6, 5'd7, 32'h1234_5678, 32'hFFFF_FFFD, 2'd0, 32'd3, 0, 0, 34, 1);
    repeat (6) tick();
    bus.fwd_data = {32'd0, 32'd2};
    issue("add_after_neg", 4'd2, 5'd1, 5'd2, 32'd10, 32'd20, 2'd0, 32'd30, 0, 0, 0, 1);
    bus.fwd_wen = 2'b00;

    // Flush during RUN cycle 5.
    issue("mul_flush", 4'd10, 5'd1, 5'd2, 32'd7, 32'd9, 2'd0, 0, 0, 0, -1, 0);
    repeat (6) tick();
    chk("pre_flush_stall", {31'd0, bus.ex_stall}, 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_stall", {31'd0, bus.ex_stall}, 32'd0);
    chk("flush_regwr", {31'd0, bus.regwr_out}, 32'd0);
    chk("flush_npc", bus.npc_out, 32'd0);
    chk("flush_result", bus.result, 32'd0);

    // rs address 0 ignores a matching forward source.
    bus.fwd_wen = 2'b01; bus.fwd_addr = {5'd0, 5'd0}; bus.fwd_data = {32'd0, 32'd77};
    issue("add_rsel0", 4'd2, 5'd0, 5'd2, 32'd9, 32'd1, 2'd0, 32'd10, 1, 32'd1, 0, 1);
    bus.fwd_wen = 2'b00;

    n = 0;
    while (q.size() != 0 && n < 200) begin tick(); n++; end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d pending expected 0", q.size());
    end
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/execute_fwd_mul.md
Name: execute_fwd_mul

Overview:
Parametrised next-generation EX stage for the pipelined core. It contains:
- the ID/EX pipeline register, with flush and stall;
- an N-source operand forwarding mux for rs and rt;
- an internal WORD_W-bit ALU;
- an iterative shift-add multiplier that stalls the front end while it runs.

Its outputs feed the EX/MEM register.

Parameters:
WORD_W, 32, datapath width (≥8).
REG_AW, 5, register address width.
NFWD, 2, number of forwarding sources; index 0 is youngest (EX/MEM), highest priority.

Ports:
CLK  in  1  clock.
nRST  in  1  asynchronous active-low reset.
ihit  in  1  pipeline advance enable.
flush  in  1  synchronous clear of the ID/EX register and the multiplier.
rsel1_in  in  REG_AW  rs address.
rsel2_in  in  REG_AW  rt address.
rdat1_in  in  WORD_W  register-file rs data.
rdat2_in  in  WORD_W  register-file rt data.
imm_in  in  WORD_W  extended immediate.
shamt_in  in  WORD_W  zero-extended shift amount.
alusrc_in  in  2  portB select: 0 rt, 1 imm, 2 shamt, 3 zero.
aluop_in  in  4  op code (see Behaviour).
npc_in  in  WORD_W  next PC.
dren_in  in  1  control passed through the register.
dwen_in  in  1  control passed through the register.
regwr_in  in  1  control passed through the register.
halt_in  in  1  control passed through the register.
regdst_in  in  REG_AW  destination address.
fwd_wen  in  NFWD  forward-source valid bits.
fwd_addr  in  NFWD*REG_AW  forward-source destination addresses.
fwd_data  in  NFWD*WORD_W  forward-source data.
result  out  WORD_W  ALU/multiplier result.
zero  out  1  result == 0.
store_dat  out  WORD_W  forwarded rt data.
npc_out, dren_out, dwen_out, regwr_out, halt_out, regdst_out  out  as inputs  registered control.
ex_stall  out  1  front end must hold.

Behaviour:
- Reset (async, nRST=0): every ID/EX field is cleared, FSM → IDLE, all multiplier registers are cleared. Consequently result=0, zero=1, ex_stall=0.
- Latch condition: ID/EX loads all *_in fields when ihit=1 && ex_stall=0.
- flush=1 at a clock edge: clears ID/EX and forces FSM → IDLE. Flush beats load and beats stall.
- Forwarding (combinational, on latched rsel1/rsel2):
  - Operand = fwd_data[i] for the lowest i with fwd_wen[i]=1, fwd_addr[i]==rsel, and rsel≠0.
  - Otherwise the latched register-file data is used.
  - Address 0 always reads the latched data.
  - store_dat = forwarded rt.
- portB selection: portB = forwarded rt / imm / shamt / 0 by alusrc.
- ALU ops:
  - 0 SLL: A<<B[log2W-1:0]. 1 SRL (same shift-amount field).
  - 2 ADD, 3 SUB (wrap modulo 2^WORD_W).
  - 4 AND, 5 OR, 6 XOR, 7 NOR.
  - 8 SLT (signed), 9 SLTU; each gives 1 or 0 zero-extended.
  - 10 MUL.
  - 11–15: result 0.
- Non-MUL latency: result is combinational from the ID/EX register, available the cycle after the latch.
- MUL FSM: IDLE → LOAD → RUN → DONE.
  - IDLE: if latched op==MUL, go to LOAD.
  - LOAD: capture forwarded A, portB and acc=0; cnt=0.
  - RUN: each cycle, if mplier[0] then acc+=mcand; then mcand<<=1, mplier>>=1, cnt++. Go to DONE after WORD_W iterations.
  - DONE: result=acc, the low WORD_W bits of the product (identical for signed and unsigned).
  - In DONE, the next latch returns FSM → IDLE.
  - If the newly latched op is another MUL, the FSM restarts from IDLE. The DONE → IDLE hop and the IDLE → LOAD hop are consecutive cycles.
- Stall: ex_stall = (latched op==MUL) && FSM≠DONE.
  - The stall therefore lasts WORD_W+2 cycles after the latch edge.
  - The result is valid on cycle WORD_W+3.
- Stall holding:
  - During RUN the multiplier ignores fwd_*; its operands are frozen at LOAD.
  - Pass-through control holds steady throughout the stall.
- Flush during LOAD or RUN aborts the multiply: acc is discarded, ex_stall drops the next cycle.
- ihit=0 in any state: nothing latches; the FSM still progresses.

Test Plan:
1. Reset mid-RUN (nRST low at cycle 10 of a multiply) → all outputs 0, zero=1, ex_stall=0 immediately, without waiting for CLK.
2. ADD, rs=3 (rdat1=5), rt=4 (rdat2=7), fwd_wen=2'b11, fwd_addr={4,4}, fwd_data={100,200}, alusrc=0 → result=205, because source 0 (data 200) wins over source 1.
3. SLT with A=0xFFFFFFFF, B=1 → result=1. SLTU with the same operands → result=0. SUB 5−5 → zero=1.
4. MUL with A=0x0001_0003, B=0x0000_0005 → ex_stall high for exactly 34 cycles, then result=0x0005_000F, and the following queued ADD latches on the first non-stall edge.
5. MUL with A=0xFFFFFFFF (−1), B=0xFFFFFFFD (−3) → result=0x00000003. Changing fwd_data during RUN has no effect.
6. Flush asserted at RUN cycle 5 → ID/EX control cleared, ex_stall=0 the following cycle, next instruction latches normally. A read with rsel=0 and a matching forward source still yields the latched value.
